sram_responder: RTL
===================

Name: sram_responder

Overview:
Slave end of the processor's SRAM-style memory port: en/wen/addr/wdata/rdata plus wait.
- Serves instruction-side or data-side requests from a word-addressed backing store.
- Drives a wait-state handshake, so the core's stall paths are exercised with non-zero memory latency.
- Used as the memory model / on-chip RAM behind either port of the processor.
- Applies the same kseg0/kseg1 physical mapping as the CPU top, so virtual addresses can be connected directly.

Parameters:
- DEPTH_LOG2, 12, log2 of word count of backing store (4096 words = 16 KiB).
- LATENCY, 0, number of wait cycles inserted per access (0..15).
- BASE_ADDR, 32'h1FC0_0000, physical base of the store; must be aligned to 2^(DEPTH_LOG2+2).

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- en  input  1  request valid; held with addr/wen/wdata stable while ram_wait=1.
- wen  input  4  byte write enables, bit i -> wdata[8i+7:8i]; 0 = read.
- addr  input  32  byte address (virtual or physical).
- wdata  input  32  write data.
- rdata  output  32  read data, valid the cycle after commit.
- ram_wait  output  1  stall request to the core.
- err  output  1  sticky flag: an access fell outside the store.

Behaviour:
- Reset (resetn=0, async): rdata=0, err=0, cnt=0, state=IDLE. ram_wait=0 because it is derived from state/cnt. Memory array is not reset.
- Address mapping: if addr[31:28] is in 8..B, then paddr = {3'b000, addr[28:0]}; otherwise paddr = addr.
  - in_range = (paddr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]).
  - index = paddr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
- State machine: IDLE, STALL.
  - ram_wait = en & (cnt != LATENCY), combinational.
  - IDLE, en=1, LATENCY=0: commit this edge; stay IDLE.
  - IDLE, en=1, LATENCY>0: ram_wait=1; cnt <= 1; go STALL.
  - STALL, en=1, cnt<LATENCY: ram_wait=1; cnt++.
  - STALL, en=1, cnt==LATENCY: ram_wait=0; commit; cnt <= 0; go IDLE.
  - Any state, en=0: abort; cnt <= 0; go IDLE; no commit; rdata holds its value.
- Commit (clock edge with en=1 and ram_wait=0):
  - Write: for each wen bit set, the corresponding memory byte takes the wdata byte.
  - Read: rdata <= mem[index] as it was before the write (read-before-write on partial writes).
  - Read latency is therefore exactly one cycle after the commit edge, regardless of LATENCY.
- Out-of-range commit: write dropped; rdata <= 32'h0; err <= 1. err stays set until reset.
- Back-to-back accesses: the next access starts counting in the cycle immediately after a commit. There is no idle bubble.
- Total cycles per access: LATENCY+1, measured from en rising to the rdata-valid cycle minus one.
- Reset mid-STALL: aborts the access; no write occurs.

Optional Feature:
- SRAM_RAND_WAIT_EN defined:
  - Per-access wait count = LATENCY + (lfsr[1:0]).
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - The LFSR steps once per commit; the target count is latched on entry to STALL or at the IDLE commit decision.
- Not defined: fixed LATENCY; no LFSR logic present.

Decomposition:
- Shared package/defines:
  - DataBus, AddrBus, WriteEn widths.
  - State encodings IDLE/STALL.
  - KSEG mapping nibble constants.
- One sub-module, sram_wait_lfsr: the 16-bit LFSR, with step-enable input and 2-bit random output. Instantiated only under SRAM_RAND_WAIT_EN.

Test Plan:
- LATENCY=0: write 32'hDEADBEEF to 0xBFC00010 with wen=4'hF, then read 0x9FC00010 (alias of the same physical word) -> ram_wait never 1; rdata=32'hDEADBEEF one cycle after the read edge.
- Byte write: word holds 32'h11223344; write wen=4'b0100 with wdata=32'h00AA0000; read back -> 32'h11AA3344. The read in the write's own commit returns 32'h11223344.
- LATENCY=3: read held on en -> ram_wait=1 for exactly 3 cycles, then drops; rdata valid on cycle 5 counted from en rising (cycle 1).
- Abort: LATENCY=3 write, drop en after 1 wait cycle -> memory unchanged on readback; next request sees the full 3 wait cycles.
- Out of range: read 0x00001000 -> rdata=0, err=1 and stays 1 through subsequent valid accesses until resetn pulses low.
- With SRAM_RAND_WAIT_EN defined and LATENCY=1: 100 reads -> every wait length is in 1..4, at least two distinct lengths occur, and data is always correct.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared widths, FSM encoding and kseg0/kseg1 mapping for the SRAM-port responder.
package sram_responder_pkg;

   localparam int unsigned DataW = 32;
   localparam int unsigned AddrW = 32;
   localparam int unsigned WenW  = 4;
   // Wide enough for LATENCY (<= 15) plus the optional random extra (<= 3)
   localparam int unsigned CntW  = 5;

   typedef logic [DataW-1:0] data_t;
   typedef logic [AddrW-1:0] addr_t;
   typedef logic [WenW-1:0]  wen_t;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StStall = 1'b1
   } state_e;

   // kseg0 (8..9) and kseg1 (A..B) alias the low 512 MiB of physical space
   localparam logic [3:0] KsegLo = 4'h8;
   localparam logic [3:0] KsegHi = 4'hB;

   function automatic addr_t map_kseg(input addr_t vaddr);
      addr_t paddr;
      paddr = vaddr;
      if (vaddr[31:28] >= KsegLo && vaddr[31:28] <= KsegHi) begin
         paddr = {3'b000, vaddr[28:0]};
      end
      return paddr;
   endfunction

endpackage

// File: rtl/sram_wait_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying a 2-bit random wait extension.
// Only instantiated when SRAM_RAND_WAIT_EN is defined.
module sram_wait_lfsr (
   input  logic       clk,
   input  logic       resetn,
   input  logic       step_i,
   output logic [1:0] rnd_o
);

   localparam logic [15:0] Seed = 16'hACE1;

   logic [15:0] lfsr_d, lfsr_q;

   // Shift one position per enabled step
   always_comb begin
      lfsr_d = lfsr_q;
      if (step_i) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   // LFSR state register, seeded on reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= Seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/sram_responder.sv
// Slave side of the SRAM-style memory port: word-addressed backing store with a
// programmable wait-state handshake and sticky out-of-range error flag.
// Optional: define SRAM_RAND_WAIT_EN to add 0..3 pseudo-random wait cycles per access.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 0,
   parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ram_wait,
   output logic        err
);

   localparam int unsigned     Words  = 1 << DEPTH_LOG2;
   localparam logic [CntW-1:0] LatCnt = CntW'(LATENCY);

   state_e                  state_d, state_q;
   logic [CntW-1:0]         cnt_d, cnt_q;
   logic [CntW-1:0]         target;
   data_t                   rdata_d, rdata_q;
   logic                    err_d, err_q;
   addr_t                   paddr;
   logic                    in_range;
   logic [DEPTH_LOG2-1:0]   index;
   logic                    commit;
   data_t                   mem [Words];

   assign paddr    = map_kseg(addr);
   assign in_range = (paddr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
   assign index    = paddr[DEPTH_LOG2+1:2];

   // Byte offset is irrelevant for a word store
   logic unused_paddr;
   assign unused_paddr = ^paddr[1:0];

`ifdef SRAM_RAND_WAIT_EN
   logic [1:0]      rnd;
   logic [CntW-1:0] tgt_d, tgt_q;

   sram_wait_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .step_i (commit),
      .rnd_o  (rnd)
   );

   // Idle uses the live random draw; the draw is frozen once the access stalls
   always_comb begin
      target = (state_q == StIdle) ? (LatCnt + CntW'(rnd)) : tgt_q;
      tgt_d  = tgt_q;
      if (state_q == StIdle && en && ram_wait) begin
         tgt_d = target;
      end
   end

   // Latched per-access wait target
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tgt_q <= LatCnt;
      end else begin
         tgt_q <= tgt_d;
      end
   end
`else
   assign target = LatCnt;
`endif

   assign ram_wait = en & (cnt_q != target);
   assign commit   = en & ~ram_wait;

   // Handshake sequencing: count wait cycles, commit when the target is reached
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (!en) begin
         // Request withdrawn: abort without touching memory or rdata
         state_d = StIdle;
         cnt_d   = '0;
      end else if (ram_wait) begin
         state_d = StStall;
         cnt_d   = cnt_q + CntW'(1);
      end else begin
         state_d = StIdle;
         cnt_d   = '0;
         if (in_range) begin
            rdata_d = mem[index];  // pre-write contents
         end else begin
            rdata_d = '0;
            err_d   = 1'b1;
         end
      end
   end

   // FSM, counter and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Byte-lane write on an in-range commit; the array itself is never reset
   always_ff @(posedge clk) begin
      if (commit && in_range) begin
         for (int b = 0; b < WenW; b++) begin
            if (wen[b]) begin
               mem[index][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;

endmodule
